rom_img_rd_ctrl: RTL and testbench
==================================

Name: rom_img_rd_ctrl

Overview:
Parametrised multi-image ROM read controller for the game display path, serving start, end, pause and similar screens. It holds IMG_NUM images of IMG_W x IMG_H pixels, stored back-to-back in one synchronous ROM. On each read request it steps a registered ROM address through the selected image, wrapping at the end of the image, and realigns the returned ROM data with its valid flag and pixel coordinates. A frame_done pulse marks the last pixel of each image.

Parameters:
IMG_W, 200, image width in pixels
IMG_H, 200, image height in pixels
IMG_NUM, 4, number of images stored consecutively in ROM
ADDR_W, 18, ROM address width; must satisfy 2^ADDR_W >= IMG_NUM*IMG_W*IMG_H
DATA_W, 8, pixel data width
ROM_LAT, 1, ROM read latency in clocks, from address to q (allowed range 1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rd_en  in  1  consume the pixel at the current rom_addr this cycle
frame_start  in  1  restart at pixel 0 of img_sel
img_sel  in  2  requested image index; values >= IMG_NUM map to 0
rom_addr  out  ADDR_W  registered address to ROM
rom_q  in  DATA_W  ROM data, valid ROM_LAT clocks after rom_addr
pix_data  out  DATA_W  pixel data aligned with pix_vld
pix_vld  out  1  pix_data, pix_x and pix_y are valid
pix_x  out  16  column of pix_data, 0..IMG_W-1
pix_y  out  16  row of pix_data, 0..IMG_H-1
frame_done  out  1  one-cycle pulse aligned with the pix_vld of the last pixel

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n) clears all registers.
- Reset values:
  - rom_addr=0, pix_data=0, pix_vld=0, pix_x=0, pix_y=0, frame_done=0.
  - Active image = 0; x/y counters = 0; valid pipeline cleared.
- Active image register (cur_img):
  - Loaded from img_sel (after range mapping) on frame_start.
  - Also reloaded on each image wrap, so img_sel changes take effect at a frame boundary without frame_start.
- Address generation:
  - rom_addr = cur_img*IMG_W*IMG_H + y_cnt*IMG_W + x_cnt.
  - Kept as a registered running sum, base + offset, with no multiplier in the per-pixel path. The base is recomputed only when cur_img loads.
- Counter stepping on rd_en (with frame_start=0):
  - x_cnt increments.
  - At x_cnt=IMG_W-1: x_cnt->0 and y_cnt increments.
  - At x=IMG_W-1 and y=IMG_H-1 (image wrap): x,y->0, cur_img reloads, and rom_addr becomes the new base on the next clock.
- rd_en=0: rom_addr and the counters hold.
- frame_start has priority over rd_en:
  - Next clock: counters=0 and rom_addr=base(img_sel).
  - A rd_en in the same cycle is discarded and generates no pix_vld.
- Valid/coordinate pipeline:
  - Delay line of ROM_LAT stages carrying {valid, x, y, last}, where valid = rd_en & ~frame_start.
  - pix_data is rom_q sampled in the same cycle the pipeline output is registered.
  - Overall latency: rd_en at cycle N -> pix_vld at cycle N+ROM_LAT+1.
  - pix_data, pix_x and pix_y hold their values while pix_vld=0.
- Reads already in the pipeline when frame_start arrives still complete with their original coordinates. No flush.
- Continuous rd_en gives one pixel per clock, so IMG_W*IMG_H reads produce exactly one frame_done.
- Reset mid-frame: all outputs return to reset values immediately; in-flight reads are lost.

Test Plan:
- Reset, then hold rd_en=1 for 40000 cycles with img_sel=0:
  - rom_addr runs 0..39999 then returns to 0.
  - pix_vld first rises 2 clocks after rd_en (ROM_LAT=1).
  - frame_done pulses once, with pix_x=199, pix_y=199.
- img_sel=2, pulse frame_start, then rd_en=1:
  - rom_addr=80000 on the first read.
  - The pixel at rom_addr=80200 reports pix_x=0, pix_y=1.
- Change img_sel from 0 to 1 mid-frame without frame_start:
  - Addresses continue in image 0 up to 39999.
  - The next address is 40000 (the image 1 base).
- rd_en and frame_start both high in the same cycle, mid-frame:
  - No pix_vld generated for that cycle.
  - Next rom_addr = base(img_sel); earlier in-flight pixels still appear with their old coordinates.
- Toggle rd_en 1/0 every cycle with ROM_LAT=3:
  - Each pix_vld pulse lags its rd_en by 4 clocks.
  - pix_data matches the ROM model contents at the matching address; the counters advance only on rd_en.
- Assert rst_n low during pixel 12345:
  - All outputs go to 0 asynchronously.
  - After release, rom_addr=0 and there is no pix_vld until the next rd_en.

Source files
------------

// File: rtl/rom_img_rd_ctrl_if.sv
// Bus bundle between the image read controller and its surroundings:
// read requests and image select in, ROM address out and ROM data back,
// plus the realigned pixel stream.
interface rom_img_rd_ctrl_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8
);
   logic              rd_en;
   logic              frame_start;
   logic [1:0]        img_sel;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_q;
   logic [DATA_W-1:0] pix_data;
   logic              pix_vld;
   logic [15:0]       pix_x;
   logic [15:0]       pix_y;
   logic              frame_done;

   // Requester/ROM side.
   modport master (
      output rd_en, frame_start, img_sel, rom_q,
      input  rom_addr, pix_data, pix_vld, pix_x, pix_y, frame_done
   );

   // Controller side.
   modport slave (
      input  rd_en, frame_start, img_sel, rom_q,
      output rom_addr, pix_data, pix_vld, pix_x, pix_y, frame_done
   );
endinterface

// File: rtl/rom_img_rd_ctrl.sv
// Multi-image ROM read controller. Images sit back-to-back in one
// synchronous ROM; each read steps a registered address through the active
// image and the ROM data is realigned with a valid flag and coordinates.
module rom_img_rd_ctrl #(
   parameter int IMG_W   = 200,
   parameter int IMG_H   = 200,
   parameter int IMG_NUM = 4,
   parameter int ADDR_W  = 18,
   parameter int DATA_W  = 8,
   parameter int ROM_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   rom_img_rd_ctrl_if.slave bus
);

   localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(IMG_W * IMG_H);
   localparam logic [15:0]       X_LAST   = 16'(IMG_W - 1);
   localparam logic [15:0]       Y_LAST   = 16'(IMG_H - 1);

   logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
   logic [15:0]       x_reg, x_next;
   logic [15:0]       y_reg, y_next;
   logic [1:0]        sel_map;
   logic [ADDR_W-1:0] sel_base;
   logic              last_pix;

   logic              vld_pipe  [ROM_LAT];
   logic              last_pipe [ROM_LAT];
   logic [15:0]       x_pipe    [ROM_LAT];
   logic [15:0]       y_pipe    [ROM_LAT];

   logic [DATA_W-1:0] pix_data_reg;
   logic              pix_vld_reg;
   logic [15:0]       pix_x_reg;
   logic [15:0]       pix_y_reg;
   logic              frame_done_reg;

   // The base multiply only feeds the load path (frame start / image wrap);
   // the per-pixel path is a plain increment of the running address.
   always_comb begin
      sel_map  = (int'(bus.img_sel) < IMG_NUM) ? bus.img_sel : 2'd0;
      sel_base = ADDR_W'(sel_map) * FRAME_SZ;
      last_pix = (x_reg == X_LAST) && (y_reg == Y_LAST);
   end

   // Next counter/address: frame_start wins, otherwise step on rd_en.
   always_comb begin
      x_next        = x_reg;
      y_next        = y_reg;
      rom_addr_next = rom_addr_reg;
      if (bus.frame_start) begin
         x_next        = '0;
         y_next        = '0;
         rom_addr_next = sel_base;
      end else if (bus.rd_en) begin
         if (last_pix) begin
            x_next        = '0;
            y_next        = '0;
            rom_addr_next = sel_base;
         end else if (x_reg == X_LAST) begin
            x_next        = '0;
            y_next        = y_reg + 16'd1;
            rom_addr_next = rom_addr_reg + ADDR_W'(1);
         end else begin
            x_next        = x_reg + 16'd1;
            rom_addr_next = rom_addr_reg + ADDR_W'(1);
         end
      end
   end

   // Address and coordinate counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_reg <= '0;
         x_reg        <= '0;
         y_reg        <= '0;
      end else begin
         rom_addr_reg <= rom_addr_next;
         x_reg        <= x_next;
         y_reg        <= y_next;
      end
   end

   // First delay stage records the request issued with the current address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe[0]  <= 1'b0;
         last_pipe[0] <= 1'b0;
         x_pipe[0]    <= '0;
         y_pipe[0]    <= '0;
      end else begin
         vld_pipe[0]  <= bus.rd_en & ~bus.frame_start;
         last_pipe[0] <= last_pix;
         x_pipe[0]    <= x_reg;
         y_pipe[0]    <= y_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < ROM_LAT; gi++) begin : g_stage
         // Extra stages match the remaining ROM latency.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_pipe[gi]  <= 1'b0;
               last_pipe[gi] <= 1'b0;
               x_pipe[gi]    <= '0;
               y_pipe[gi]    <= '0;
            end else begin
               vld_pipe[gi]  <= vld_pipe[gi-1];
               last_pipe[gi] <= last_pipe[gi-1];
               x_pipe[gi]    <= x_pipe[gi-1];
               y_pipe[gi]    <= y_pipe[gi-1];
            end
         end
      end
   endgenerate

   // Output register: capture ROM data with its coordinates, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_data_reg   <= '0;
         pix_vld_reg    <= 1'b0;
         pix_x_reg      <= '0;
         pix_y_reg      <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         pix_vld_reg    <= vld_pipe[ROM_LAT-1];
         frame_done_reg <= vld_pipe[ROM_LAT-1] & last_pipe[ROM_LAT-1];
         if (vld_pipe[ROM_LAT-1]) begin
            pix_data_reg <= bus.rom_q;
            pix_x_reg    <= x_pipe[ROM_LAT-1];
            pix_y_reg    <= y_pipe[ROM_LAT-1];
         end
      end
   end

   assign bus.rom_addr   = rom_addr_reg;
   assign bus.pix_data   = pix_data_reg;
   assign bus.pix_vld    = pix_vld_reg;
   assign bus.pix_x      = pix_x_reg;
   assign bus.pix_y      = pix_y_reg;
   assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_rom_img_rd_ctrl.sv
// Bench for rom_img_rd_ctrl: one instance with ROM_LAT=1 and one with
// ROM_LAT=3, each with its own ROM model, stimulus thread and reset.
module tb_rom_img_rd_ctrl;
   localparam int W  = 200;
   localparam int H  = 200;
   localparam int F  = W * H;
   localparam int AW = 18;
   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       rstn [2];
   logic       rd   [2];
   logic       fs   [2];
   logic [1:0] sel  [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int lat [2] = '{1, 3};

   // Model state: active image, coordinates, timestamped request log.
   int m_img [2];
   int m_x   [2];
   int m_y   [2];
   bit lg_v  [2][8];
   bit lg_l  [2][8];
   int lg_d  [2][8];
   int lg_x  [2][8];
   int lg_y  [2][8];
   int h_d   [2];
   int h_x   [2];
   int h_y   [2];

   always #5 clk = ~clk;

   rom_img_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
   rom_img_rd_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

   assign bus0.rd_en       = rd[0];
   assign bus0.frame_start = fs[0];
   assign bus0.img_sel     = sel[0];
   assign bus1.rd_en       = rd[1];
   assign bus1.frame_start = fs[1];
   assign bus1.img_sel     = sel[1];

   rom_img_rd_ctrl #(.IMG_W(W), .IMG_H(H), .IMG_NUM(4), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1))
      dut0 (.clk(clk), .rst_n(rstn[0]), .bus(bus0));
   rom_img_rd_ctrl #(.IMG_W(W), .IMG_H(H), .IMG_NUM(4), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3))
      dut1 (.clk(clk), .rst_n(rstn[1]), .bus(bus1));

   function automatic logic [7:0] rom_fn(input int a);
      return 8'((a ^ (a >> 8) ^ (a >> 16) ^ 'h5A) & 'hFF);
   endfunction

   // Synchronous ROMs of latency 1 and 3.
   logic [7:0] r0;
   logic [7:0] r1 [3];
   always @(posedge clk) begin
      r0    <= rom_fn(int'(bus0.rom_addr));
      r1[0] <= rom_fn(int'(bus1.rom_addr));
      r1[1] <= r1[0];
      r1[2] <= r1[1];
   end
   assign bus0.rom_q = r0;
   assign bus1.rom_q = r1[2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Model: at every clock record the request, then advance the image walk.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         for (int k = 0; k < 2; k++) begin
            if (!rstn[k]) begin
               m_img[k] = 0; m_x[k] = 0; m_y[k] = 0;
               for (int j = 0; j < 8; j++) lg_v[k][j] = 1'b0;
            end else begin
               int idx;
               bit last;
               idx  = cyc % 8;
               last = (m_x[k] == W-1) && (m_y[k] == H-1);
               lg_v[k][idx] = rd[k] && !fs[k];
               lg_l[k][idx] = last;
               lg_d[k][idx] = int'(rom_fn(m_img[k]*F + m_y[k]*W + m_x[k]));
               lg_x[k][idx] = m_x[k];
               lg_y[k][idx] = m_y[k];
               if (fs[k]) begin
                  m_img[k] = (int'(sel[k]) < 4) ? int'(sel[k]) : 0;
                  m_x[k] = 0; m_y[k] = 0;
               end else if (rd[k]) begin
                  if (last) begin
                     m_img[k] = (int'(sel[k]) < 4) ? int'(sel[k]) : 0;
                     m_x[k] = 0; m_y[k] = 0;
                  end else if (m_x[k] == W-1) begin
                     m_x[k] = 0; m_y[k]++;
                  end else begin
                     m_x[k]++;
                  end
               end
            end
         end
      end
   end

   task automatic cmp(input int k, input logic [63:0] a, input logic [63:0] v,
                      input logic [63:0] d, input logic [63:0] x, input logic [63:0] y,
                      input logic [63:0] fd);
      int j;
      string p;
      p = $sformatf("dut%0d.", k);
      if (!rstn[k]) begin
         h_d[k] = 0; h_x[k] = 0; h_y[k] = 0;
         chk({p, "rst_rom_addr"}, a, 0);
         chk({p, "rst_pix_vld"}, v, 0);
         chk({p, "rst_pix_data"}, d, 0);
         chk({p, "rst_pix_x"}, x, 0);
         chk({p, "rst_pix_y"}, y, 0);
         chk({p, "rst_frame_done"}, fd, 0);
      end else begin
         j = (cyc - lat[k] + 8) % 8;
         if (lg_v[k][j]) begin
            h_d[k] = lg_d[k][j]; h_x[k] = lg_x[k][j]; h_y[k] = lg_y[k][j];
         end
         chk({p, "rom_addr"}, a, m_img[k]*F + m_y[k]*W + m_x[k]);
         chk({p, "pix_vld"}, v, lg_v[k][j]);
         chk({p, "pix_data"}, d, h_d[k]);
         chk({p, "pix_x"}, x, h_x[k]);
         chk({p, "pix_y"}, y, h_y[k]);
         chk({p, "frame_done"}, fd, lg_v[k][j] && lg_l[k][j]);
      end
   endtask

   // Compare process: every falling edge, both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         cmp(0, bus0.rom_addr, bus0.pix_vld, bus0.pix_data, bus0.pix_x, bus0.pix_y, bus0.frame_done);
         cmp(1, bus1.rom_addr, bus1.pix_vld, bus1.pix_data, bus1.pix_x, bus1.pix_y, bus1.frame_done);
      end
   end

   // Watchdog.
   initial begin
      #1500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      rstn[0] = 1'b0; rd[0] = 1'b0; fs[0] = 1'b0; sel[0] = 2'd0;
      rstn[1] = 1'b0; rd[1] = 1'b0; fs[1] = 1'b0; sel[1] = 2'd0;
      fork
         begin : seq0
            int fd_cnt, fd_x, fd_y, np;
            fd_cnt = 0; fd_x = -1; fd_y = -1;
            repeat (3) step();
            rstn[0] = 1'b1;
            step();
            chk("dut0.lit_reset_addr", bus0.rom_addr, 0);
            chk("dut0.lit_reset_vld", bus0.pix_vld, 0);
            rd[0] = 1'b1;
            for (int i = 1; i <= 80000; i++) begin
               step();
               if (bus0.frame_done) begin
                  fd_cnt++; fd_x = int'(bus0.pix_x); fd_y = int'(bus0.pix_y);
               end
               if (i == 1) chk("dut0.lit_first_vld_low", bus0.pix_vld, 0);
               if (i == 2) begin
                  chk("dut0.lit_first_vld", bus0.pix_vld, 1);
                  chk("dut0.lit_first_x", bus0.pix_x, 0);
                  chk("dut0.lit_first_y", bus0.pix_y, 0);
                  chk("dut0.lit_first_data", bus0.pix_data, rom_fn(0));
               end
               if (i == 39999) chk("dut0.lit_addr_39999", bus0.rom_addr, 39999);
               if (i == 40000) chk("dut0.lit_wrap_to_0", bus0.rom_addr, 0);
               if (i == 40100) sel[0] = 2'd1;
               if (i == 79999) chk("dut0.lit_img0_end", bus0.rom_addr, 39999);
               if (i == 80000) begin
                  chk("dut0.lit_img1_base", bus0.rom_addr, 40000);
                  rd[0] = 1'b0;
               end
            end
            chk("dut0.lit_fd_count", fd_cnt, 1);
            chk("dut0.lit_fd_x", fd_x, 199);
            chk("dut0.lit_fd_y", fd_y, 199);
            step();
            sel[0] = 2'd2; fs[0] = 1'b1;
            step();
            fs[0] = 1'b0;
            chk("dut0.lit_img2_base", bus0.rom_addr, 80000);
            rd[0] = 1'b1;
            np = 0;
            for (int i = 0; i < 210; i++) begin
               step();
               if (bus0.pix_vld) begin
                  if (np == 200) begin
                     chk("dut0.lit_80200_x", bus0.pix_x, 0);
                     chk("dut0.lit_80200_y", bus0.pix_y, 1);
                     chk("dut0.lit_80200_data", bus0.pix_data, rom_fn(80200));
                  end
                  np++;
               end
            end
            chk("dut0.lit_img2_count", np, 209);
            sel[0] = 2'd3; fs[0] = 1'b1;
            step();
            fs[0] = 1'b0;
            chk("dut0.lit_coll_addr", bus0.rom_addr, 120000);
            chk("dut0.lit_coll_old_vld", bus0.pix_vld, 1);
            chk("dut0.lit_coll_old_x", bus0.pix_x, 9);
            chk("dut0.lit_coll_old_y", bus0.pix_y, 1);
            step();
            chk("dut0.lit_coll_drop", bus0.pix_vld, 0);
            step();
            chk("dut0.lit_coll_new_vld", bus0.pix_vld, 1);
            chk("dut0.lit_coll_new_x", bus0.pix_x, 0);
            chk("dut0.lit_coll_new_y", bus0.pix_y, 0);
            chk("dut0.lit_coll_new_data", bus0.pix_data, rom_fn(120000));
            rd[0] = 1'b0;
            repeat (4) step();
         end
         begin : seq1
            bit hv [28];
            int np, guard;
            repeat (3) step();
            rstn[1] = 1'b1;
            np = 0;
            for (int i = 0; i < 28; i++) begin
               step();
               chk("dut1.lit_lag4", bus1.pix_vld, (i >= 4) ? hv[i-4] : 1'b0);
               if (bus1.pix_vld) begin
                  chk("dut1.lit_toggle_x", bus1.pix_x, np);
                  chk("dut1.lit_toggle_data", bus1.pix_data, rom_fn(np));
                  np++;
               end
               hv[i] = (i < 16) && (i % 2 == 0);
               rd[1] = hv[i];
            end
            chk("dut1.lit_toggle_count", np, 8);
            chk("dut1.lit_toggle_addr", bus1.rom_addr, 8);
            rd[1] = 1'b1;
            guard = 0;
            while (bus1.rom_addr != 18'd12345 && guard < 20000) begin
               step();
               guard++;
            end
            chk("dut1.lit_reach_12345", guard < 20000, 1);
            rstn[1] = 1'b0; rd[1] = 1'b0;
            #1;
            chk("dut1.lit_async_addr", bus1.rom_addr, 0);
            chk("dut1.lit_async_vld", bus1.pix_vld, 0);
            chk("dut1.lit_async_x", bus1.pix_x, 0);
            chk("dut1.lit_async_y", bus1.pix_y, 0);
            chk("dut1.lit_async_data", bus1.pix_data, 0);
            chk("dut1.lit_async_fd", bus1.frame_done, 0);
            repeat (2) step();
            rstn[1] = 1'b1;
            for (int i = 0; i < 4; i++) begin
               step();
               chk("dut1.lit_post_rst_addr", bus1.rom_addr, 0);
               chk("dut1.lit_post_rst_vld", bus1.pix_vld, 0);
            end
            rd[1] = 1'b1;
            for (int j = 1; j <= 6; j++) begin
               step();
               if (j == 1) rd[1] = 1'b0;
               if (j == 4) begin
                  chk("dut1.lit_restart_vld", bus1.pix_vld, 1);
                  chk("dut1.lit_restart_x", bus1.pix_x, 0);
                  chk("dut1.lit_restart_y", bus1.pix_y, 0);
                  chk("dut1.lit_restart_data", bus1.pix_data, rom_fn(0));
               end else begin
                  chk("dut1.lit_restart_idle", bus1.pix_vld, 0);
               end
            end
         end
      join
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
